// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers, stalls decode on unresolvable RAW hazards
// and produces registered bypass selects for the instruction entering stage 1.
module hazard_scoreboard #(
    parameter int DEPTH      = 4,
    parameter int FORWARD    = 1,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 32,
    parameter int FWD_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [31:2]      issue_instr,
    input  logic             pipe_hold,
    input  logic             flush,
    output logic             stall,
    output logic [FWD_W-1:0] ex_fwd_rs1,
    output logic [FWD_W-1:0] ex_fwd_rs2,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [DEPTH-1:1]      valid_q, valid_d, ld_q, ld_d;
    logic [DEPTH-1:1][4:0] rd_q, rd_d;
    logic [FWD_W-1:0]      fwd1_q, fwd1_d, fwd2_q, fwd2_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4:0]            opc, rd, src1, src2;
    logic                  use_rs1, use_rs2, is_wr, accept;
    logic [FWD_W:0]        res1, res2;
    logic                  unused;

    assign unused = ^{issue_instr[31:25], issue_instr[14:12]};
    assign opc    = issue_instr[6:2];
    assign rd     = issue_instr[11:7];

    // Returns {hazard, select}; walking from the youngest stage makes the first hit win.
    function automatic logic [FWD_W:0] resolve(input logic [4:0] src, input logic [DEPTH-1:1] v,
                                               input logic [DEPTH-1:1][4:0] r, input logic [DEPTH-1:1] l);
        logic           found;
        logic [FWD_W:0] res;
        found = 1'b0;
        res   = '0;
        for (int s = 1; s < DEPTH; s++) begin
            if (!found && src != 5'd0 && v[s] && r[s] == src) begin
                found = 1'b1;
                res   = (FORWARD == 0 || s == DEPTH - 1 || (l[s] && s < LOAD_STAGE))
                        ? {1'b1, {FWD_W{1'b0}}} : {1'b0, FWD_W'(s + 1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        use_rs1 = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH, OPC_LOAD, OPC_JALR, OPC_OP_IMM};
        use_rs2 = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        is_wr   = (opc inside {OPC_LOAD, OPC_JALR, OPC_JAL, OPC_OP_IMM, OPC_OP, OPC_AUIPC, OPC_LUI}) && rd != 5'd0;
        src1    = use_rs1 ? issue_instr[19:15] : 5'd0;
        src2    = use_rs2 ? issue_instr[24:20] : 5'd0;
        res1    = resolve(src1, valid_q, rd_q, ld_q);
        res2    = resolve(src2, valid_q, rd_q, ld_q);
        stall   = issue_valid & (res1[FWD_W] | res2[FWD_W]);
        accept  = issue_valid & ~stall & ~flush & ~pipe_hold;
        valid_d = pipe_hold ? valid_q : {valid_q[DEPTH-2:1], accept & is_wr};
        rd_d    = pipe_hold ? rd_q : {rd_q[DEPTH-2:1], rd};
        ld_d    = pipe_hold ? ld_q : {ld_q[DEPTH-2:1], opc == OPC_LOAD};
        fwd1_d  = pipe_hold ? fwd1_q : accept ? res1[FWD_W-1:0] : '0;
        fwd2_d  = pipe_hold ? fwd2_q : accept ? res2[FWD_W-1:0] : '0;
        cnt_d   = (issue_valid & stall & ~flush & ~pipe_hold & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            fwd1_q  <= '0;
            fwd2_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_fwd_rs1   = fwd1_q;
    assign ex_fwd_rs2   = fwd2_q;
    assign stall_cycles = cnt_q;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard unit for the in-order integer pipeline. It tracks destination registers in flight across `DEPTH-1` post-decode stages in its own shift register and gates issue from decode. In forwarding mode it resolves RAW hazards by bypass selects, stalling only on load-use and last-stage conflicts; in non-forwarding mode it stalls on any match. It also keeps a saturating stall-cycle counter.

## Interface
- `DEPTH`, 4: pipeline stages including decode (stage 0). Tracked stages are 1..DEPTH-1; DEPTH ≥ 3.
- `FORWARD`, 1: 1 = bypass mode, 0 = stall-only mode.
- `LOAD_STAGE`, 2: first stage whose output holds load data; 2 ≤ LOAD_STAGE ≤ DEPTH-2.
- `CNT_W`, 32: stall counter width.
- `FWD_W`, $clog2(DEPTH): width of the forward selects.

- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `issue_valid` input 1: decode holds a valid instruction.
- `issue_instr` input [31:2]: decode instruction (bits 1:0 implied 2'b11).
- `pipe_hold` input 1: global freeze (memory wait); no entry moves.
- `flush` input 1: kill the decode instruction this cycle.
- `stall` output 1: decode must not advance.
- `ex_fwd_rs1` output FWD_W: registered bypass select for rs1 of the instruction now in stage 1; 0 = register file, s = output of stage s.
- `ex_fwd_rs2` output FWD_W: same for rs2.
- `stall_cycles` output CNT_W: saturating count of stall cycles.

## Operation
- **Source use (opcode [6:2]):**
  - OP, STORE, BRANCH: rs1 and rs2.
  - LOAD, JALR, OP_IMM: rs1 only.
  - LUI, AUIPC, JAL, SYSTEM, others: none.
  - An unused source is treated as x0.
- **Writers:** LOAD, JALR, JAL, OP_IMM, OP, AUIPC, LUI with rd ≠ 0. Each entry stores {valid, rd, is_load}.
- **Match:** for each used source ≠ x0, find the youngest valid entry (lowest stage s) with rd = source.
- **FORWARD=0:** any match gives hazard.
- **FORWARD=1:** a match is a hazard if s = DEPTH-1, or if is_load and s < LOAD_STAGE. Otherwise it is forwardable with select s+1.
- `stall` = issue_valid & (hazard on rs1 or rs2). This is combinational.
- `accept` = issue_valid & !stall & !flush & !pipe_hold.
- **Shift when !pipe_hold:**
  - entry[1] ← accept ? decode writer info : bubble.
  - entry[k] ← entry[k-1].
  - entry[DEPTH-1] retires.
- **Forward selects when !pipe_hold:** `ex_fwd_rs1`/`ex_fwd_rs2` ← accept ? (forwardable ? s+1 : 0) : 0.
- **pipe_hold:** entries, selects and counter hold. `stall` is still evaluated.
- **flush:** inserts a bubble into stage 1 and does not touch older entries. flush together with pipe_hold has no extra effect.
- **Counter:** `stall_cycles` increments when issue_valid & stall & !flush & !pipe_hold, and saturates at all-ones.

## Timing
- **Reset (async, immediate):** all entries invalid; `ex_fwd_rs1` = `ex_fwd_rs2` = 0; `stall_cycles` = 0; `stall` = 0.
- **Reset mid-operation:** all in-flight tracking is lost. The pipeline is reset together with this block.
- `stall` has zero-cycle latency from `issue_instr`.
- Selects are valid one cycle after accept, aligned with the consumer in stage 1.
- **Load-use (FORWARD=1, LOAD_STAGE=2):** 1 stall cycle, then forward from stage 3.
- **FORWARD=0, back-to-back dependency:** DEPTH-1 stall cycles.
- **Multiple matches:** the youngest wins. rs1 and rs2 resolve independently.
- **Same register for rs1 and rs2:** both selects are equal.

## Test plan
1. **Reset defaults:** assert rst_n low mid-stream -> stall = 0, both selects = 0 and stall_cycles = 0 immediately; entries are empty after release.
2. **ALU bypass (DEPTH=4, FORWARD=1):** `addi x5,x0,1` then `add x6,x5,x5` next cycle -> stall = 0; next cycle ex_fwd_rs1 = ex_fwd_rs2 = 2.
3. **Load-use:** `lw x5,0(x1)` then `add x6,x5,x0` -> stall = 1 for exactly 1 cycle, then accepted with ex_fwd_rs1 = 3, ex_fwd_rs2 = 0; stall_cycles = 1.
4. **Stall-only mode (FORWARD=0):** `addi x5` then `add x6,x5,x0` -> stall for 3 cycles, accepted on the 4th with selects 0; stall_cycles = 3.
5. **x0 and unused fields:**
   - `addi x0,x0,1` then `add x6,x0,x0` -> no stall.
   - `addi x7` then `lui x8` whose bits [19:15] = 7 -> no stall.
6. **Hold and flush:**
   - Load-use stall with pipe_hold asserted 2 cycles -> stall stays 1 and stall_cycles is unchanged during the hold.
   - flush in the next cycle -> bubble into stage 1, selects = 0, load entry still advances.
